// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-channel DDS controller:
// waveform modes, front-panel key bit positions and decimal digit weights.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_TABLE  = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_NEXT  = 4;

  // Weight of display digit idx; idx 5 is the units digit.
  function automatic logic [19:0] pow10(input logic [2:0] idx);
    logic [19:0] w;
    case (idx)
      3'd0:    w = 20'd100000;
      3'd1:    w = 20'd10000;
      3'd2:    w = 20'd1000;
      3'd3:    w = 20'd100;
      3'd4:    w = 20'd10;
      3'd5:    w = 20'd1;
      default: w = 20'd1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: tuning-word register, phase accumulator, and a mode mux whose
// computed waveforms are delayed one stage so every mode lines up with the ROM path.
module dds_channel
  import dds_pkg::*;
#(
  parameter int PHASE_W    = 32,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int FTW_PER_HZ = 86,
  parameter int FREQ_DEF   = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [19:0]       freq,
  input  mode_e             mode,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] dac
);

  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  logic [PHASE_W-1:0] ftw_r;
  logic [PHASE_W-1:0] phase_r;
  mode_e              mode_d_r;
  logic               sq_d_r;
  logic [DATA_W-1:0]  saw_d_r;
  logic [DATA_W-1:0]  dac_s;

  assign rom_addr = phase_r[PHASE_W-1 -: ADDR_W];

  // Accumulator, tuning word and the alignment stage that parallels the ROM read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ftw_r    <= PHASE_W'(FREQ_DEF * FTW_PER_HZ);
      phase_r  <= '0;
      mode_d_r <= MODE_OFF;
      sq_d_r   <= 1'b0;
      saw_d_r  <= '0;
    end else begin
      ftw_r    <= PHASE_W'(freq) * PHASE_W'(FTW_PER_HZ);
      phase_r  <= phase_r + ftw_r;
      mode_d_r <= mode;
      sq_d_r   <= phase_r[PHASE_W-1];
      saw_d_r  <= phase_r[PHASE_W-1 -: DATA_W];
    end
  end

  // The aligned-stage mode is held at OFF through reset so no stale ROM word
  // reaches the DAC while the address pipeline refills.
  always_comb begin
    dac_s = MID;
    case (mode_d_r)
      MODE_TABLE:  dac_s = rom_q;
      MODE_SQUARE: dac_s = {DATA_W{sq_d_r}};
      MODE_SAW:    dac_s = saw_d_r;
      MODE_OFF:    dac_s = MID;
      default:     dac_s = MID;
    endcase
  end

  // DAC output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dac <= MID;
    end else begin
      dac <= dac_s;
    end
  end

endmodule

// File: rtl/dds_multi_dac_ctrl.sv
// Multi-channel DDS controller: key edge detection, digit/channel selection,
// per-channel frequency and mode registers, display registers and the channel array.
module dds_multi_dac_ctrl
  import dds_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int PHASE_W    = 32,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int FTW_PER_HZ = 86,
  parameter int FREQ_MIN   = 50,
  parameter int FREQ_MAX   = 25000,
  parameter int FREQ_DEF   = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4:0]               key_i,
  input  logic                     key_mode_i,
  output logic [NUM_CH*ADDR_W-1:0] rom_addr_o,
  input  logic [NUM_CH*DATA_W-1:0] rom_q_i,
  output logic [NUM_CH*DATA_W-1:0] dac_o,
  output logic [19:0]              disp_num_o,
  output logic [5:0]               digit_sel_o,
  output logic [1:0]               ch_sel_o,
  output logic [1:0]               mode_o
);

  localparam int CH_W = 2;

  logic [4:0]      key_prev_r;
  logic [4:0]      key_rise_s;
  logic [2:0]      idx_r;
  logic [CH_W-1:0] ch_sel_r;
  logic [19:0]     freq_r [NUM_CH];
  mode_e           mode_r [NUM_CH];

  logic            up_s, down_s, left_s, right_s, next_s;
  logic [19:0]     weight_s;
  logic [19:0]     freq_sel_s;
  mode_e           mode_sel_s;
  logic [20:0]     sum_s;
  logic [20:0]     floor_s;
  logic            up_ok_s, down_ok_s;
  logic [CH_W-1:0] ch_next_s;

  assign key_rise_s = key_i & ~key_prev_r;
  // Opposing keys pressed together cancel each other.
  assign up_s    = key_rise_s[KEY_UP]    & ~key_rise_s[KEY_DOWN];
  assign down_s  = key_rise_s[KEY_DOWN]  & ~key_rise_s[KEY_UP];
  assign left_s  = key_rise_s[KEY_LEFT]  & ~key_rise_s[KEY_RIGHT];
  assign right_s = key_rise_s[KEY_RIGHT] & ~key_rise_s[KEY_LEFT];
  assign next_s  = key_rise_s[KEY_NEXT];

  assign weight_s  = pow10(idx_r);
  assign sum_s     = {1'b0, freq_sel_s} + {1'b0, weight_s};
  assign floor_s   = {1'b0, weight_s} + 21'(FREQ_MIN);
  assign up_ok_s   = (sum_s <= 21'(FREQ_MAX));
  assign down_ok_s = ({1'b0, freq_sel_s} >= floor_s);
  assign ch_next_s = (ch_sel_r == CH_W'(NUM_CH - 1)) ? 2'd0 : ch_sel_r + 2'd1;

  // Selected-channel view of the frequency and mode arrays.
  always_comb begin
    freq_sel_s = 20'd0;
    mode_sel_s = MODE_TABLE;
    for (int c = 0; c < NUM_CH; c++) begin
      freq_sel_s = (ch_sel_r == CH_W'(c)) ? freq_r[c] : freq_sel_s;
      mode_sel_s = (ch_sel_r == CH_W'(c)) ? mode_r[c] : mode_sel_s;
    end
  end

  // Front-panel state: key history, digit cursor, channel select, freq/mode per channel.
  always_ff @(posedge clk) begin
    key_prev_r <= key_i;
    if (!rst_n) begin
      idx_r    <= 3'd5;
      ch_sel_r <= 2'd0;
      for (int c = 0; c < NUM_CH; c++) begin
        freq_r[c] <= 20'(FREQ_DEF);
        mode_r[c] <= MODE_TABLE;
      end
    end else begin
      if (left_s) begin
        idx_r <= (idx_r == 3'd0) ? 3'd5 : idx_r - 3'd1;
      end else if (right_s) begin
        idx_r <= (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel_r == CH_W'(c)) begin
          if (up_s && up_ok_s) begin
            freq_r[c] <= freq_r[c] + weight_s;
          end else if (down_s && down_ok_s) begin
            freq_r[c] <= freq_r[c] - weight_s;
          end
          if (next_s && key_mode_i) begin
            mode_r[c] <= mode_e'(mode_r[c] + 2'd1);
          end
        end
      end
      if (next_s && !key_mode_i) begin
        ch_sel_r <= ch_next_s;
      end
    end
  end

  // Display and status registers, one clock behind the state they report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_num_o  <= 20'(FREQ_DEF);
      digit_sel_o <= 6'b000001;
      ch_sel_o    <= 2'd0;
      mode_o      <= 2'd0;
    end else begin
      disp_num_o  <= freq_sel_s;
      digit_sel_o <= 6'd1 << (3'd5 - idx_r);
      ch_sel_o    <= ch_sel_r;
      mode_o      <= mode_sel_s;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dds_channel #(
      .PHASE_W   (PHASE_W),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .FTW_PER_HZ(FTW_PER_HZ),
      .FREQ_DEF  (FREQ_DEF)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .freq    (freq_r[g]),
      .mode    (mode_r[g]),
      .rom_q   (rom_q_i[g*DATA_W +: DATA_W]),
      .rom_addr(rom_addr_o[g*ADDR_W +: ADDR_W]),
      .dac     (dac_o[g*DATA_W +: DATA_W])
    );
  end

endmodule
